mips_mem_server: RTL and testbench
==================================

Name: mips_mem_server

Overview:
- Memory-side responder for the single-cycle `mips` core.
- Serves `instr` for `pc` and `readdata` for `aluout`, and commits core stores (`memwrite`/`writedata`).
- Owns a program-load front end: holds the core in reset, streams program words into instruction memory, optionally clears data memory, then releases the core.
- Replaces the hand-driven `instr`/`readdata` stimulus used around the core today.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words (power of two).
- DMEM_WORDS, 64, data memory depth in 32-bit words (power of two).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ld_valid  in  1  load stream word valid.
- ld_ready  out  1  load stream ready.
- ld_data  in  32  program word.
- ld_last  in  1  marks final program word.
- core_reset  out  1  active-high reset to the core.
- running  out  1  high in RUN state.
- pc  in  32  core fetch byte address.
- instr  out  32  fetched instruction.
- memwrite  in  1  core store strobe.
- aluout  in  32  core data byte address.
- writedata  in  32  core store data.
- readdata  out  32  load data to the core.
- err  out  1  sticky access-error flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOAD, load_cnt=0, clr_cnt=0, err=0.
  - core_reset=1, running=0, ld_ready=0 for the reset cycle itself; ld_ready=1 from the first clock after release.
  - instr=0, readdata=0.
- FSM states LOAD -> CLEAR -> RUN.
- LOAD:
  - ld_ready=1.
  - Transfer occurs when ld_valid&&ld_ready at a rising edge: imem[load_cnt]<=ld_data, load_cnt++.
  - Exit to CLEAR when a transfer has ld_last=1, or when the transfer writes index IMEM_WORDS-1 (stream truncated, no wrap).
  - ld_valid=0 holds state; no timeout.
- CLEAR:
  - ld_ready=0.
  - dmem[clr_cnt]<=0, one word per cycle, for exactly DMEM_WORDS cycles.
  - Then go to RUN.
- RUN:
  - core_reset=0, running=1, ld_ready=0.
  - Load-port inputs are ignored.
  - RUN is held until reset.
- core_reset is registered: it deasserts on the same edge that enters RUN.
- Instruction fetch (combinational, RUN only, otherwise 0):
  - idx=pc[log2(IMEM_WORDS)+1:2].
  - instr=imem[idx] if pc[1:0]==0, pc < 4*IMEM_WORDS and idx < load_cnt.
  - instr=0 (nop) otherwise.
  - pc misaligned or pc >= 4*IMEM_WORDS sets err. Unloaded index returns 0 without err.
- Data read (combinational):
  - readdata=dmem[aluout[log2(DMEM_WORDS)+1:2]] when in RUN, aluout aligned and aluout < 4*DMEM_WORDS.
  - Otherwise readdata=0. No err on read: aluout is not always an address.
- Data write (at rising edge):
  - Commits when running && memwrite && aluout aligned && in range.
  - Visible on readdata combinationally from the following cycle; write-then-read same cycle returns old data.
  - A misaligned or out-of-range store is dropped and sets err.
- err is sticky until reset; it sets at the rising edge following the offending condition.
- Reset mid-operation (any state):
  - Immediate return to LOAD and core_reset=1.
  - imem/dmem contents are not cleared by reset. Stale imem is masked by load_cnt=0 until reloaded.

Optional Feature:
- Macro: DMEM_CLEAR_EN.
- Defined: CLEAR state present as above. A fresh run reads 0 from every dmem word until written.
- Undefined: LOAD transitions directly to RUN on the exit condition, with no CLEAR cycles. dmem retains prior contents (X after power-up). Release latency is shortened by DMEM_WORDS cycles.

Test Plan:
- Load 0x2010000a, 0x2011000f, 0x02114020 (ld_last on third, ld_valid continuous) -> ld_ready 1 for 3 cycles. With DMEM_CLEAR_EN: core_reset falls exactly 64 cycles after the last transfer. Then pc=0 gives instr=0x2010000a, pc=8 gives 0x02114020, pc=12 gives 0, and err=0.
- RUN, memwrite=1, aluout=0x14, writedata=0x00000036 for one cycle -> same cycle readdata at 0x14 unchanged (0); next cycle readdata=0x36.
- RUN, memwrite=1, aluout=0x15 -> no write (readdata at 0x14 stays 0x36), err=1 after the edge and remains 1.
- RUN, pc=0x100 (IMEM_WORDS=64) -> instr=0, err=1.
- Stream 64 words with ld_last never asserted -> exit after the 64th transfer, ld_ready=0 afterwards; a 65th ld_valid is ignored.
- Mid-RUN assert reset=0 -> core_reset=1, running=0, instr=0 without waiting for clk. After release, ld_ready=1 and a reload of 1 word with ld_last gives instr at pc=4 = 0.

Source files
------------

// File: rtl/mips_mem_server.sv
// Memory-side responder for the single-cycle mips core: program-load front end,
// instruction/data memories and a sticky access-error flag. Optional macro: DMEM_CLEAR_EN.
module mips_mem_server #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        core_reset,
  output logic        running,
  input  logic [31:0] pc,
  output logic [31:0] instr,
  input  logic        memwrite,
  input  logic [31:0] aluout,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        err
);

  localparam int IW = $clog2(IMEM_WORDS);
  localparam int DW = $clog2(DMEM_WORDS);
  localparam logic [IW:0] LOAD_LAST = (IW+1)'(IMEM_WORDS - 1);
  localparam logic [IW:0] LOAD_ONE  = (IW+1)'(1);

  typedef enum logic [1:0] {S_LOAD, S_CLEAR, S_RUN} state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [IW:0] r_load_cnt;
  logic        r_err;
  logic        r_core_reset;
  logic        r_ld_ready;
  logic [31:0] r_imem [IMEM_WORDS];
  logic [31:0] r_dmem [DMEM_WORDS];
`ifdef DMEM_CLEAR_EN
  localparam logic [DW-1:0] CLR_LAST = DW'(DMEM_WORDS - 1);
  logic [DW-1:0] r_clr_cnt;
`endif

  logic          w_xfer;
  logic [IW-1:0] w_pc_idx;
  logic          w_pc_ok;
  logic [DW-1:0] w_d_idx;
  logic          w_d_ok;
  logic          w_dwr;
  logic          w_fetch_bad;
  logic          w_store_bad;

  assign running    = (r_state == S_RUN);
  assign core_reset = r_core_reset;
  assign ld_ready   = r_ld_ready;
  assign err        = r_err;

  assign w_xfer   = (r_state == S_LOAD) && r_ld_ready && ld_valid;

  // Word index plus explicit alignment/range qualification; out-of-range never aliases.
  assign w_pc_idx = pc[IW+1:2];
  assign w_pc_ok  = (pc[1:0] == 2'b00) && (pc[31:IW+2] == '0);
  assign w_d_idx  = aluout[DW+1:2];
  assign w_d_ok   = (aluout[1:0] == 2'b00) && (aluout[31:DW+2] == '0);

  assign instr    = (running && w_pc_ok && ({1'b0, w_pc_idx} < r_load_cnt)) ? r_imem[w_pc_idx] : '0;
  assign readdata = (running && w_d_ok) ? r_dmem[w_d_idx] : '0;

  assign w_dwr       = running && memwrite && w_d_ok;
  assign w_store_bad = running && memwrite && !w_d_ok;
  assign w_fetch_bad = running && !w_pc_ok;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_LOAD: begin
        if (w_xfer && (ld_last || (r_load_cnt == LOAD_LAST))) begin
`ifdef DMEM_CLEAR_EN
          w_next_state = S_CLEAR;
`else
          w_next_state = S_RUN;
`endif
        end
      end
      S_CLEAR: begin
`ifdef DMEM_CLEAR_EN
        if (r_clr_cnt == CLR_LAST) w_next_state = S_RUN;
`else
        w_next_state = S_LOAD;
`endif
      end
      S_RUN:   w_next_state = S_RUN;
      default: w_next_state = S_LOAD;
    endcase
  end

  // ld_ready and core_reset are registered from the next state so they change on the transition edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_LOAD;
      r_load_cnt   <= '0;
      r_err        <= 1'b0;
      r_core_reset <= 1'b1;
      r_ld_ready   <= 1'b0;
`ifdef DMEM_CLEAR_EN
      r_clr_cnt    <= '0;
`endif
    end else begin
      r_state      <= w_next_state;
      if (w_xfer) r_load_cnt <= r_load_cnt + LOAD_ONE;
      r_err        <= r_err | w_fetch_bad | w_store_bad;
      r_core_reset <= (w_next_state != S_RUN);
      r_ld_ready   <= (w_next_state == S_LOAD);
`ifdef DMEM_CLEAR_EN
      if (r_state == S_CLEAR) r_clr_cnt <= r_clr_cnt + DW'(1);
`endif
    end
  end

  // Memory arrays are deliberately not reset; stale imem is masked by r_load_cnt.
  always_ff @(posedge clk) begin
    if (w_xfer) r_imem[r_load_cnt[IW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk) begin
    if (w_dwr) r_dmem[w_d_idx] <= writedata;
`ifdef DMEM_CLEAR_EN
    else if (r_state == S_CLEAR) r_dmem[r_clr_cnt] <= '0;
`endif
  end

endmodule

// File: tb/tb_mips_mem_server.sv
// Self-checking bench for mips_mem_server: fetch table, randomized run against a
// word-level memory model, and hand sequences for load, store, error and reset corners.
module tb_mips_mem_server;

  localparam int IMEM_WORDS = 64;
  localparam int DMEM_WORDS = 64;
`ifdef DMEM_CLEAR_EN
  localparam int EXP_LAT  = DMEM_WORDS;
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam int EXP_LAT  = 0;
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        ld_valid;
  logic        ld_ready;
  logic [31:0] ld_data;
  logic        ld_last;
  logic        core_reset;
  logic        running;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        memwrite;
  logic [31:0] aluout;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        err;

  mips_mem_server #(.IMEM_WORDS(IMEM_WORDS), .DMEM_WORDS(DMEM_WORDS)) dut (
    .clk(clk), .reset(reset),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
    .core_reset(core_reset), .running(running),
    .pc(pc), .instr(instr),
    .memwrite(memwrite), .aluout(aluout), .writedata(writedata), .readdata(readdata),
    .err(err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model: word arrays plus a loaded-word count
  logic [31:0] m_imem [IMEM_WORDS];
  int          m_load_cnt;
  logic [31:0] m_dmem [DMEM_WORDS];
  bit          m_known [DMEM_WORDS];
  logic [31:0] ld_words [$];
  logic [31:0] exp_q [$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] exp_instr;
  } fetch_vec_t;
  fetch_vec_t fv [5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit m_addr_ok(input logic [31:0] a, input int words);
    return (a % 4 == 0) && (a < 32'(4 * words));
  endfunction

  function automatic logic [31:0] m_instr(input logic [31:0] a);
    if (!m_addr_ok(a, IMEM_WORDS)) return 32'h0;
    if (int'(a / 4) >= m_load_cnt) return 32'h0;
    return m_imem[a / 4];
  endfunction

  function automatic bit m_rd_known(input logic [31:0] a);
    if (!m_addr_ok(a, DMEM_WORDS)) return 1'b1;
    return m_known[a / 4];
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a);
    if (!m_addr_ok(a, DMEM_WORDS)) return 32'h0;
    return m_dmem[a / 4];
  endfunction

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    pc = 32'h0; aluout = 32'h14; memwrite = 1'b0; ld_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_core_reset", 32'(core_reset), 32'h1);
    chk("async_running", 32'(running), 32'h0);
    chk("async_instr", instr, 32'h0);
    chk("async_readdata", readdata, 32'h0);
    chk("async_err", 32'(err), 32'h0);
    m_load_cnt = 0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("ld_ready_after_release", 32'(ld_ready), 32'h1);
  endtask

  task automatic do_load(input bit use_last, input bit extra_valid);
    int k;
    int n;
    n = ld_words.size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ld_valid = 1'b1;
      ld_data  = ld_words[i];
      ld_last  = use_last && (i == n - 1);
      #1 chk("ld_ready_during_load", 32'(ld_ready), 32'h1);
      @(posedge clk);
      if (m_load_cnt < IMEM_WORDS) begin
        m_imem[m_load_cnt] = ld_words[i];
        m_load_cnt++;
      end
    end
    @(negedge clk);
    ld_valid = extra_valid;
    ld_data  = 32'hffff_ffff;
    ld_last  = 1'b0;
    #1 chk("ld_ready_after_exit", 32'(ld_ready), 32'h0);
    k = 0;
    while (core_reset === 1'b1 && k < 500) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      k++;
    end
    chk("release_latency", 32'(k), 32'(EXP_LAT));
    chk("running_after_release", 32'(running), 32'h1);
    chk("ld_ready_in_run", 32'(ld_ready), 32'h0);
    if (CLEAR_EN) begin
      for (int i = 0; i < DMEM_WORDS; i++) begin
        m_dmem[i]  = 32'h0;
        m_known[i] = 1'b1;
      end
    end
  endtask

  task automatic rand_run(input int n);
    logic [31:0] p;
    logic [31:0] a;
    logic [31:0] wd;
    bit          we;
    for (int i = 0; i < n; i++) begin
      p = 32'(4 * $urandom_range(0, IMEM_WORDS - 1));
      if ($urandom_range(0, 9) < 7) begin
        a  = 32'(4 * $urandom_range(0, DMEM_WORDS - 1));
        we = ($urandom_range(0, 1) == 1);
      end else begin
        a  = 32'($urandom_range(0, 1023));
        we = 1'b0;
      end
      wd = $urandom;
      @(negedge clk);
      pc = p; aluout = a; memwrite = we; writedata = wd;
      #1;
      chk("rand_instr", instr, m_instr(p));
      if (m_rd_known(a)) chk("rand_readdata", readdata, m_rd(a));
      @(posedge clk);
      if (we && m_addr_ok(a, DMEM_WORDS)) begin
        m_dmem[a / 4]  = wd;
        m_known[a / 4] = 1'b1;
      end
    end
    @(negedge clk);
    memwrite = 1'b0;
    #1 chk("rand_err", 32'(err), 32'h0);
  endtask

  initial begin
    fv[0] = '{32'h0000_0000, 32'h2010_000a};
    fv[1] = '{32'h0000_0004, 32'h2011_000f};
    fv[2] = '{32'h0000_0008, 32'h0211_4020};
    fv[3] = '{32'h0000_000c, 32'h0000_0000};
    fv[4] = '{32'h0000_00fc, 32'h0000_0000};
    for (int i = 0; i < DMEM_WORDS; i++) m_known[i] = 1'b0;
    m_load_cnt = 0;

    reset = 1'b0; ld_valid = 1'b0; ld_data = 32'h0; ld_last = 1'b0;
    pc = 32'h0; memwrite = 1'b0; aluout = 32'h0; writedata = 32'h0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_core_reset", 32'(core_reset), 32'h1);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_ld_ready", 32'(ld_ready), 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("ld_ready_after_release", 32'(ld_ready), 32'h1);

    // three-word program with ld_last on the final word
    ld_words = '{32'h2010_000a, 32'h2011_000f, 32'h0211_4020};
    do_load(1'b1, 1'b0);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      pc = fv[i].pc;
      #1 chk("fetch_table", instr, fv[i].exp_instr);
    end
    @(negedge clk);
    #1 chk("fetch_table_err", 32'(err), 32'h0);

    rand_run(300);

    // store visible only from the following cycle
    @(negedge clk);
    pc = 32'h0; aluout = 32'h14; memwrite = 1'b1; writedata = 32'h0;
    @(posedge clk);
    m_dmem[5] = 32'h0; m_known[5] = 1'b1;
    @(negedge clk);
    writedata = 32'h36;
    #1 chk("store_same_cycle_old", readdata, 32'h0);
    @(posedge clk);
    m_dmem[5] = 32'h36;
    @(negedge clk);
    memwrite = 1'b0;
    #1 chk("store_next_cycle", readdata, 32'h36);
    chk("store_ok_err", 32'(err), 32'h0);

    // misaligned store is dropped and flags err after the edge
    @(negedge clk);
    aluout = 32'h15; memwrite = 1'b1; writedata = 32'h77;
    #1 chk("misaligned_read_zero", readdata, 32'h0);
    chk("err_before_edge", 32'(err), 32'h0);
    @(negedge clk);
    aluout = 32'h14; memwrite = 1'b0;
    #1 chk("misaligned_store_dropped", readdata, 32'h36);
    chk("err_after_bad_store", 32'(err), 32'h1);
    @(negedge clk);
    #1 chk("err_sticky", 32'(err), 32'h1);

    // mid-run reset and a one-word reload
    do_reset();
    ld_words = '{32'h1234_5678};
    do_load(1'b1, 1'b0);
    @(negedge clk);
    pc = 32'h4;
    #1 chk("reload_unloaded_idx", instr, 32'h0);
    @(negedge clk);
    pc = 32'h0; aluout = 32'h14;
    #1 chk("reload_idx0", instr, 32'h1234_5678);
    chk("reload_dmem", readdata, m_rd(32'h14));
    chk("reload_err", 32'(err), 32'h0);

    // fetch beyond imem
    @(negedge clk);
    pc = 32'h100;
    #1 chk("fetch_oob_instr", instr, 32'h0);
    chk("fetch_oob_err_before", 32'(err), 32'h0);
    @(negedge clk);
    pc = 32'h0;
    #1 chk("fetch_oob_err_after", 32'(err), 32'h1);

    // truncated stream: 64 words, no ld_last, extra valid held afterwards
    do_reset();
    ld_words.delete();
    exp_q.delete();
    for (int i = 0; i < IMEM_WORDS; i++) begin
      ld_words.push_back($urandom);
      exp_q.push_back(ld_words[i]);
    end
    do_load(1'b0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      #1 chk("trunc_ld_ready_low", 32'(ld_ready), 32'h0);
    end
    ld_valid = 1'b0;
    for (int i = 0; i < IMEM_WORDS; i++) begin
      @(negedge clk);
      pc = 32'(4 * i);
      #1 chk("trunc_fetch", instr, exp_q.pop_front());
    end
    @(negedge clk);
    pc = 32'h0; aluout = 32'h14;
    #1 chk("trunc_err", 32'(err), 32'h0);
    chk("trunc_dmem", readdata, m_rd(32'h14));

    // misaligned fetch
    @(negedge clk);
    pc = 32'h6;
    #1 chk("fetch_misaligned_instr", instr, 32'h0);
    @(negedge clk);
    pc = 32'h0;
    #1 chk("fetch_misaligned_err", 32'(err), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
